shift_reg_ctrl: RTL and testbench

Command sequencer for the 4-bit bidirectional shift register datapath. It accepts load, clear and multi-bit shift commands over a valid/ready handshake and expands each into a cycle-exact sequence of `sr_load` / `sr_shiftR` / `sr_d_in` / `sr_en` strobes. It then reports completion. It sits between a bus-side or test-side command source and the register instance, which holds its value whenever `sr_en` is low.

---
 rtl/shift_reg_ctrl.sv | 152 +++++++++++++++
 tb/tb_shift_reg_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_ctrl.sv
// rtl/shift_reg_ctrl.sv - command sequencer for the shift register datapath
// Optional shadow checker: define SHIFT_REG_CTRL_SHADOW_EN.
module shift_reg_ctrl #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic             sr_en,
  output logic             sr_load,
  output logic             sr_shiftR,
  output logic             sr_clr,
  output logic             sr_d_in,
  input  logic [WIDTH-1:0] sr_d_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             mismatch
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  localparam logic [1:0]       OP_LOAD    = 2'b00;
  localparam logic [1:0]       OP_SHR     = 2'b01;
  localparam logic [1:0]       OP_CLR     = 2'b11;
  localparam logic [LEN_W-1:0] LP_MAX_LEN = LEN_W'(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_op;
  logic [LEN_W-1:0] r_len;
  logic [WIDTH-1:0] r_data;
  logic [LEN_W-1:0] r_cnt;
  logic             r_aborted;
  logic [LEN_W-1:0] w_len_clamped;
  logic             w_accept;
  logic             w_last;

  assign w_accept      = cmd_valid && (r_state == S_IDLE);
  assign w_len_clamped = (cmd_len > LP_MAX_LEN) ? LP_MAX_LEN : cmd_len;
  assign w_last        = ((r_cnt + LEN_W'(1)) == r_len);

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    aborted   = 1'b0;
    sr_en     = 1'b0;
    sr_load   = 1'b0;
    sr_clr    = 1'b0;
    sr_shiftR = 1'b0;
    sr_d_in   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_op == OP_LOAD || cmd_op == OP_CLR) w_next = S_LOAD;
          else if (w_len_clamped != '0)              w_next = S_SHIFT;
          else                                       w_next = S_DONE;
        end
      end
      S_LOAD: begin
        busy   = 1'b1;
        w_next = S_DONE;
        if (!abort) begin
          sr_en   = 1'b1;
          sr_load = (r_op == OP_LOAD);
          sr_clr  = (r_op == OP_CLR);
          sr_d_in = (r_op == OP_LOAD) && r_data[0];
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (abort) begin
          w_next = S_DONE;
        end else begin
          sr_en     = 1'b1;
          sr_shiftR = (r_op == OP_SHR);
          sr_d_in   = r_data[0];
          if (w_last) w_next = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        aborted = r_aborted;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_data is consumed LSB-first by shifting it down one bit per issued step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_len     <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op      <= cmd_op;
        r_len     <= w_len_clamped;
        r_data    <= cmd_data;
        r_cnt     <= '0;
        r_aborted <= 1'b0;
      end
      if ((r_state == S_LOAD || r_state == S_SHIFT) && abort) r_aborted <= 1'b1;
      if (sr_en && r_state == S_SHIFT) begin
        r_data <= r_data >> 1;
        r_cnt  <= r_cnt + LEN_W'(1);
      end
    end
  end

`ifdef SHIFT_REG_CTRL_SHADOW_EN
  logic [WIDTH-1:0] r_shadow;
  logic             r_mismatch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow   <= '0;
      r_mismatch <= 1'b0;
    end else begin
      if (sr_en) begin
        if (sr_load)        r_shadow <= {{(WIDTH-1){1'b0}}, sr_d_in};
        else if (sr_clr)    r_shadow <= '0;
        else if (sr_shiftR) r_shadow <= {sr_d_in, r_shadow[WIDTH-1:1]};
        else                r_shadow <= {r_shadow[WIDTH-2:0], sr_d_in};
      end
      if ((r_state == S_IDLE || r_state == S_DONE) && (r_shadow != sr_d_out))
        r_mismatch <= 1'b1;
    end
  end

  assign mismatch = r_mismatch;
`else
  logic w_unused_d_out;
  assign w_unused_d_out = ^sr_d_out;
  assign mismatch       = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb/tb_shift_reg_ctrl.sv - scoreboard bench for shift_reg_ctrl with datapath model
module tb_shift_reg_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_len;
  logic [3:0] cmd_data;
  logic       abort;
  logic       sr_en, sr_load, sr_shiftR, sr_clr, sr_d_in;
  logic [3:0] sr_d_out;
  logic       busy, done, aborted, mismatch;

  always #5 clk = ~clk;

  shift_reg_ctrl #(.WIDTH(4), .LEN_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .abort(abort),
    .sr_en(sr_en), .sr_load(sr_load), .sr_shiftR(sr_shiftR),
    .sr_clr(sr_clr), .sr_d_in(sr_d_in), .sr_d_out(sr_d_out),
    .busy(busy), .done(done), .aborted(aborted), .mismatch(mismatch)
  );

`ifdef SHIFT_REG_CTRL_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  // 4-bit datapath register driven by the controller's strobes
  logic [3:0] dp_q;
  logic       force_ones = 1'b0;
  assign sr_d_out = force_ones ? 4'hF : dp_q;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)       dp_q <= 4'h0;
    else if (sr_en) begin
      if (sr_load)        dp_q <= {3'b000, sr_d_in};
      else if (sr_clr)    dp_q <= 4'h0;
      else if (sr_shiftR) dp_q <= {sr_d_in, dp_q[3:1]};
      else                dp_q <= {dp_q[2:0], sr_d_in};
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_done;
    int         cyc;
    bit         load, clr, shr, din, ab;
    logic [3:0] regv;
  } ev_t;

  ev_t        exp_q[$];
  logic [3:0] exp_reg = 4'h0;
  bit         exp_mismatch = 1'b0;
  bit         mon_en = 1'b0;
  bit         prev_done = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_step(input int c, input bit ld, input bit cl, input bit sh, input bit d);
    ev_t e;
    e.is_done = 1'b0; e.cyc = c; e.load = ld; e.clr = cl; e.shr = sh; e.din = d;
    e.ab = 1'b0; e.regv = 4'h0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int c, input bit ab);
    ev_t e;
    e.is_done = 1'b1; e.cyc = c; e.load = 0; e.clr = 0; e.shr = 0; e.din = 0;
    e.ab = ab; e.regv = exp_reg;
    exp_q.push_back(e);
  endtask

  // reference model: the full strobe/done timeline of one accepted command
  task automatic expect_cmd(input logic [1:0] op, input int len, input logic [3:0] data, input int acc);
    int n;
    bit b;
    if (op == 2'b00) begin
      push_step(acc + 1, 1, 0, 0, data[0]);
      exp_reg = {3'b000, data[0]};
      push_done(acc + 2, 0);
    end else if (op == 2'b11) begin
      push_step(acc + 1, 0, 1, 0, 0);
      exp_reg = 4'h0;
      push_done(acc + 2, 0);
    end else begin
      n = (len > 4) ? 4 : len;
      for (int i = 0; i < n; i++) begin
        b = data[i];
        push_step(acc + 1 + i, 0, 0, op == 2'b01, b);
        if (op == 2'b01) exp_reg = (exp_reg >> 1) | (4'(b) << 3);
        else             exp_reg = (exp_reg << 1) | 4'(b);
      end
      push_done(acc + 1 + n, 0);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] len, input logic [3:0] data, output int acc);
    int t = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", {31'd0, cmd_ready}, 32'd1);
    acc = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_len = 3'($urandom); cmd_data = 4'($urandom);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [2:0] len, input logic [3:0] data);
    int acc;
    issue(op, len, data, acc);
    expect_cmd(op, int'(len), data, acc);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (reset_n && mon_en) begin
      if (sr_en) begin
        if (exp_q.size() == 0) check("unexpected_step", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("step_kind", e.is_done, 0);
          check("step_cycle", cyc, e.cyc);
          check("step_strobes", {sr_load, sr_clr, sr_shiftR, sr_d_in}, {e.load, e.clr, e.shr, e.din});
          check("step_busy", busy, 1);
        end
      end else begin
        check("idle_strobes", {sr_load, sr_clr, sr_shiftR, sr_d_in}, 0);
      end
      if (done) begin
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("done_kind", e.is_done, 1);
          check("done_cycle", cyc, e.cyc);
          check("done_aborted", aborted, e.ab);
          check("done_register", dp_q, e.regv);
          check("done_ready_low", cmd_ready, 0);
        end
      end else begin
        check("aborted_without_done", aborted, 0);
      end
      if (prev_done) check("ready_after_done", cmd_ready, 1);
      prev_done <= done;
      check("mismatch", mismatch, exp_mismatch);
    end
  end

  initial begin
    int acc;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = 3'd0; cmd_data = 4'h0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {cmd_ready, busy, done, aborted, sr_en, sr_load, sr_shiftR, sr_clr, sr_d_in, mismatch},
          10'b10_0000_0000);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {cmd_ready, busy, done, sr_en}, 4'b1000);
    mon_en = 1'b1;

    run_cmd(2'b00, 3'd4, 4'b0001);
    run_cmd(2'b10, 3'd4, 4'b1011);
    run_cmd(2'b01, 3'd7, 4'b0110);
    run_cmd(2'b01, 3'd0, 4'b1111);
    run_cmd(2'b11, 3'd2, 4'b1010);
    run_cmd(2'b10, 3'd1, 4'b0001);
    for (int i = 0; i < 30; i++)
      run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom));
    drain();

    // abort during the second SHIFT step: only the first step is issued
    issue(2'b10, 3'd4, 4'b0101, acc);
    push_step(acc + 1, 0, 0, 0, 1'b1);
    exp_reg = (exp_reg << 1) | 4'h1;
    push_done(acc + 3, 1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    drain();

    // abort on a LOAD: no step at all
    issue(2'b00, 3'd0, 4'b0001, acc);
    abort = 1'b1;
    push_done(acc + 2, 1);
    @(posedge clk); #1 abort = 1'b0;
    drain();

    // asynchronous reset in the middle of a SHIFT
    issue(2'b10, 3'd4, 4'b1001, acc);
    expect_cmd(2'b10, 4, 4'b1001, acc);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    check("reset_mid_shift", {sr_en, busy, cmd_ready, done}, 4'b0010);
    exp_q.delete();
    exp_reg = 4'h0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    run_cmd(2'b01, 3'd3, 4'b0111);
    drain();

    // datapath disagrees with the shadow after a CLEAR
    run_cmd(2'b11, 3'd0, 4'b0000);
    drain();
    force_ones = 1'b1;
    @(posedge clk); #1 exp_mismatch = SHADOW;
    repeat (2) @(negedge clk);
    force_ones = 1'b0;
    repeat (3) @(negedge clk);
    check("mismatch_sticky", mismatch, SHADOW);
    reset_n = 1'b0;
    #1 exp_mismatch = 1'b0;
    check("mismatch_reset", mismatch, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("queue_empty_at_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
